// File: rtl/pc_fetch_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// pc_fetch_ctrl
//
// Program-counter register and instruction-fetch sequencer. It captures the
// next PC chosen by the upstream next-PC select stage, requests that word
// from instruction memory, and holds the returned instruction until decode
// takes it. Flush redirects the PC. A fetch that waits too long for an
// acknowledge parks the block in a sticky fault state that only reset clears.
//
// Parameters:
//   N        data / instruction width (also width of next_pc and flush_pc)
//   Pb       PC width; next_pc / flush_pc are truncated to their Pb LSBs
//   RESET_PC PC loaded on reset
//   TIMEOUT  consecutive unacknowledged request cycles before fault (2..255)
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          asynchronous active-high reset
//   next_pc      next PC from the next-PC select stage (used at hand-off)
//   flush        one-cycle redirect request
//   flush_pc     redirect target, valid with flush
//   stall        blocks the instruction hand-off while high
//   imem_req     instruction-memory read request
//   imem_addr    read address, always equal to pc
//   imem_ack     qualifies imem_rdata for the address presented this cycle
//   imem_rdata   instruction word from memory
//   instr        held instruction for decode
//   instr_valid  instr is valid for decode
//   instr_ready  decode accepts instr
//   pc           current PC, fed back to the next-PC select stage
//   fault        sticky fetch-timeout flag
// ---------------------------------------------------------------------------
module pc_fetch_ctrl #(
  parameter int            N        = 32,
  parameter int            Pb       = 32,
  parameter logic [Pb-1:0] RESET_PC = '0,
  parameter int            TIMEOUT  = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  next_pc,
  input  logic          flush,
  input  logic [N-1:0]  flush_pc,
  input  logic          stall,
  output logic          imem_req,
  output logic [Pb-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [N-1:0]  imem_rdata,
  output logic [N-1:0]  instr,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [Pb-1:0] pc,
  output logic          fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t        state_q, state_nxt;
  logic [Pb-1:0] pc_q, pc_nxt;
  logic [N-1:0]  instr_q, instr_nxt;
  logic [7:0]    cnt_q, cnt_nxt;

  // Next-state and datapath decisions. Everything defaults to holding its
  // current value, so only the events that actually change state are spelled
  // out below. Flush is checked first in every live state because a redirect
  // must override an acknowledge, a timeout or a decode hand-off. FAULT has
  // no exits here on purpose: only reset gets the block out of it.
  always_comb begin
    state_nxt = state_q;
    pc_nxt    = pc_q;
    instr_nxt = instr_q;
    cnt_nxt   = cnt_q;

    case (state_q)
      IDLE: begin
        state_nxt = REQ;
        if (flush) begin
          pc_nxt  = flush_pc[Pb-1:0];
          cnt_nxt = '0;
        end
      end

      REQ: begin
        if (flush) begin
          pc_nxt  = flush_pc[Pb-1:0];
          cnt_nxt = '0;
        end else if (imem_ack) begin
          instr_nxt = imem_rdata;
          cnt_nxt   = '0;
          state_nxt = HOLD;
        end else if (cnt_q == CNT_LAST) begin
          state_nxt = FAULT;
        end else begin
          cnt_nxt = cnt_q + 8'd1;
        end
      end

      HOLD: begin
        if (flush) begin
          pc_nxt    = flush_pc[Pb-1:0];
          cnt_nxt   = '0;
          state_nxt = REQ;
        end else if (instr_ready && !stall) begin
          pc_nxt    = next_pc[Pb-1:0];
          state_nxt = REQ;
        end
      end

      FAULT: begin
        state_nxt = FAULT;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register. Reset is asynchronous so that a reset arriving in the
  // middle of a fetch drops the request and the valid flag at once rather
  // than waiting for the next clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      pc_q    <= pc_nxt;
      instr_q <= instr_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  // The handshake flags are pure decodes of the registered state, which
  // keeps every output glitch-free and free of input-to-output paths.
  assign imem_req    = (state_q == REQ);
  assign instr_valid = (state_q == HOLD);
  assign fault       = (state_q == FAULT);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_pc_fetch_ctrl
//
// Testbench for pc_fetch_ctrl built with N=64, Pb=32 so the truncation of the
// upper next_pc / flush_pc bits is exercised throughout. Expected fetch
// addresses and expected decode hand-offs are queued by the stimulus code; a
// monitor on the falling edge pops and compares them whenever the DUT issues
// an acknowledged fetch or completes a decode hand-off. Cycle-exact
// properties (stall hold, timeout boundary, async reset) are checked
// directly from the stimulus process.
// ---------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

  localparam int N  = 64;
  localparam int Pb = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  next_pc;
  logic          flush;
  logic [N-1:0]  flush_pc;
  logic          stall;
  logic          imem_req;
  logic [Pb-1:0] imem_addr;
  logic          imem_ack;
  logic [N-1:0]  imem_rdata;
  logic [N-1:0]  instr;
  logic          instr_valid;
  logic          instr_ready;
  logic [Pb-1:0] pc;
  logic          fault;

  logic          npc_mode;
  logic [N-1:0]  npc_fixed;
  logic          use_fixed;
  logic [N-1:0]  fixed_word;

  int total = 0;
  int bad   = 0;

  logic [Pb-1:0] exp_addr_q[$];
  logic [N-1:0]  exp_instr_q[$];

  pc_fetch_ctrl #(
    .N        (N),
    .Pb       (Pb),
    .RESET_PC (32'h0),
    .TIMEOUT  (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .next_pc     (next_pc),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc          (pc),
    .fault       (fault)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Memory contents are a fixed function of the address, so the expected
  // instruction for any fetch follows directly from the fetched address.
  function automatic logic [N-1:0] mem_word(input logic [Pb-1:0] addr);
    return {~addr, addr ^ 32'h5A5A_0000};
  endfunction

  // Memory and next-PC-select models that respond to the DUT outputs.
  assign imem_rdata = use_fixed ? fixed_word : mem_word(imem_addr);
  assign next_pc    = npc_mode ? {32'h0, pc + 32'd1} : npc_fixed;

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic a_ack, input logic a_ready,
                               input logic a_stall, input logic a_flush,
                               input logic [N-1:0] a_flush_pc);
    imem_ack    = a_ack;
    instr_ready = a_ready;
    stall       = a_stall;
    flush       = a_flush;
    flush_pc    = a_flush_pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: sampled on the falling edge, half a cycle away from
  // the active edge. An acknowledged fetch not cancelled by flush consumes an
  // expected address; a hand-off to decode consumes an expected instruction.
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_req && imem_ack && !flush) begin
        if (exp_addr_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_fetch: got addr %h expected none", imem_addr);
        end else begin
          checkOutput("fetch_addr", 64'(imem_addr), 64'(exp_addr_q.pop_front()));
        end
      end
      if (instr_valid && instr_ready && !stall && !flush) begin
        if (exp_instr_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_handoff: got instr %h expected none", instr);
        end else begin
          checkOutput("handoff_instr", instr, exp_instr_q.pop_front());
        end
      end
    end
  end

  // Safety net so the run always ends even if something wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus.
  initial begin
    rst        = 1'b1;
    npc_mode   = 1'b0;
    npc_fixed  = '0;
    use_fixed  = 1'b0;
    fixed_word = '0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    tick();

    $display("[TB] reset state");
    checkOutput("rst_pc", 64'(pc), 64'h0);
    checkOutput("rst_req", 64'(imem_req), 64'h0);
    checkOutput("rst_valid", 64'(instr_valid), 64'h0);
    checkOutput("rst_fault", 64'(fault), 64'h0);
    checkOutput("rst_instr", instr, 64'h0);

    $display("[TB] sequential fetch");
    for (int i = 0; i < 5; i++) exp_addr_q.push_back(32'(i));
    for (int i = 0; i < 4; i++) exp_instr_q.push_back(mem_word(32'(i)));
    npc_mode = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput("seq_req", 64'(imem_req), 64'((i % 2) == 0));
      checkOutput("seq_valid", 64'(instr_valid), 64'((i % 2) == 1));
      checkOutput("seq_addr", 64'(imem_addr), 64'(i / 2));
      checkOutput("seq_fault", 64'(fault), 64'h0);
    end

    $display("[TB] stall hold");
    use_fixed  = 1'b1;
    fixed_word = 64'h0000_0000_1234_5678;
    tick();
    stall = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      checkOutput("stall_instr", instr, 64'h0000_0000_1234_5678);
      checkOutput("stall_pc", 64'(pc), 64'h4);
      checkOutput("stall_valid", 64'(instr_valid), 64'h1);
    end
    exp_instr_q.push_back(64'h0000_0000_1234_5678);
    exp_addr_q.push_back(32'h5);
    exp_instr_q.push_back(mem_word(32'h5));
    stall = 1'b0;
    tick();
    checkOutput("stall_release_pc", 64'(pc), 64'h5);
    checkOutput("stall_release_req", 64'(imem_req), 64'h1);

    $display("[TB] jump and flush");
    use_fixed = 1'b0;
    npc_mode  = 1'b0;
    npc_fixed = 64'hFFFF_FFFF_0000_0040;
    tick();
    tick();
    checkOutput("jump_addr", 64'(imem_addr), 64'h40);
    checkOutput("jump_req", 64'(imem_req), 64'h1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_0100);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
    checkOutput("flush_pc", 64'(pc), 64'h100);
    checkOutput("flush_req", 64'(imem_req), 64'h1);
    checkOutput("flush_valid", 64'(instr_valid), 64'h0);
    checkOutput("flush_instr", instr, mem_word(32'h5));

    $display("[TB] fetch timeout");
    for (int k = 2; k <= 16; k++) begin
      tick();
      checkOutput("to_req", 64'(imem_req), 64'h1);
      checkOutput("to_fault", 64'(fault), 64'h0);
    end
    tick();
    checkOutput("to_fault_set", 64'(fault), 64'h1);
    checkOutput("to_fault_req", 64'(imem_req), 64'h0);
    checkOutput("to_fault_valid", 64'(instr_valid), 64'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 64'h0000_0000_0000_0200);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
    tick();
    checkOutput("fault_flush_fault", 64'(fault), 64'h1);
    checkOutput("fault_flush_pc", 64'(pc), 64'h100);
    checkOutput("fault_flush_req", 64'(imem_req), 64'h0);
    rst = 1'b1;
    #1;
    checkOutput("fault_rst_fault", 64'(fault), 64'h0);
    checkOutput("fault_rst_pc", 64'(pc), 64'h0);

    $display("[TB] ack on last request cycle");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
    npc_fixed = 64'h0000_0000_0000_0007;
    tick();
    rst = 1'b0;
    tick();
    for (int k = 2; k <= 16; k++) begin
      tick();
      checkOutput("late_req", 64'(imem_req), 64'h1);
      checkOutput("late_fault", 64'(fault), 64'h0);
    end
    use_fixed  = 1'b1;
    fixed_word = 64'h0000_0000_CAFE_F00D;
    exp_addr_q.push_back(32'h0);
    imem_ack = 1'b1;
    tick();
    checkOutput("late_valid", 64'(instr_valid), 64'h1);
    checkOutput("late_nofault", 64'(fault), 64'h0);
    checkOutput("late_instr", instr, 64'h0000_0000_CAFE_F00D);
    exp_instr_q.push_back(64'h0000_0000_CAFE_F00D);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
    tick();
    checkOutput("late_next_pc", 64'(pc), 64'h7);
    checkOutput("late_next_req", 64'(imem_req), 64'h1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_req", 64'(imem_req), 64'h0);
    checkOutput("async_rst_valid", 64'(instr_valid), 64'h0);
    checkOutput("async_rst_pc", 64'(pc), 64'h0);

    $display("[TB] pc wrap");
    use_fixed = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
    tick();
    rst = 1'b0;
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 64'h0000_0000_FFFF_FFFF);
    exp_addr_q.push_back(32'hFFFF_FFFF);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
    checkOutput("wrap_start_pc", 64'(pc), 64'hFFFF_FFFF);
    tick();
    npc_fixed = 64'h0000_0001_0000_0000;
    exp_instr_q.push_back(mem_word(32'hFFFF_FFFF));
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
    checkOutput("wrap_pc", 64'(pc), 64'h0);
    checkOutput("wrap_req", 64'(imem_req), 64'h1);
    checkOutput("wrap_fault", 64'(fault), 64'h0);
    tick();
    tick();

    checkOutput("addr_queue_left", 64'(exp_addr_q.size()), 64'h0);
    checkOutput("instr_queue_left", 64'(exp_instr_q.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
